// File: rtl/uart_mem_pkg.sv
// Definitions shared by the UART memory dumper and its loader counterpart:
// default geometry, framing bytes and the dumper state encoding.
package uart_mem_pkg;

   localparam int INSTR_WIDTH_DEF = 32;
   localparam int DEPTH_DEF       = 256;
   localparam int BYTES_PER_WORD  = INSTR_WIDTH_DEF / 8;
   localparam int ADDR_W          = $clog2(DEPTH_DEF);

   localparam logic [7:0] START_BYTE_DEF = 8'hFF;
   localparam logic [7:0] END_BYTE_DEF   = 8'hFE;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_HDR_W,
      S_RD,
      S_LAT,
      S_CAP,
      S_DAT,
      S_DAT_W,
      S_END,
      S_END_W
   } dumper_state_t;

endpackage

// File: rtl/uart_tx_byte_sender.sv
// Owns the UART TX handshake: one tx_en per requested byte, then holds off
// further strobes until the transmitter reports tx_done.
module uart_tx_byte_sender (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req,
   input  logic [7:0] i_byte,
   input  logic       i_tx_busy,
   input  logic       i_tx_done,
   output logic [7:0] o_tx_byte,
   output logic       o_tx_en,
   output logic       o_ack
);

   logic r_wait;

   assign o_tx_en   = i_req & ~i_tx_busy & ~r_wait;
   // A tx_done that does not answer our own strobe is ignored.
   assign o_ack     = r_wait & i_tx_done;
   assign o_tx_byte = i_byte;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of its neighbours, whatever the block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wait <= 1'b0;
      else if (o_tx_en)
         r_wait <= 1'b1;
      else if (i_tx_done)
         r_wait <= 1'b0;
   end

endmodule

// File: rtl/uart_mem_dumper.sv
// Streams a range of instruction memory to the UART TX as
// START_BYTE, words MSB-first, END_BYTE - the same layout the loader accepts.
module uart_mem_dumper
   import uart_mem_pkg::*;
#(
   parameter int         INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int         DEPTH       = DEPTH_DEF,
   parameter logic [7:0] START_BYTE  = START_BYTE_DEF,
   parameter logic [7:0] END_BYTE    = END_BYTE_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [$clog2(DEPTH)-1:0] start_addr,
   input  logic [$clog2(DEPTH):0]   word_count,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
   input  logic [INSTR_WIDTH-1:0]   mem_rd_data,
   output logic [7:0]               tx_byte,
   output logic                     tx_en,
   input  logic                     tx_busy,
   input  logic                     tx_done
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int BPW = INSTR_WIDTH / 8;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;

   dumper_state_t          r_state, w_next;
   logic [AW-1:0]          r_addr;
   logic [CW-1:0]          r_count;
   logic [INSTR_WIDTH-1:0] r_shreg;
   logic [BIW-1:0]         r_bidx;
   logic [AW-1:0]          r_mem_rd_addr;
   logic                   r_done;

   logic                   w_req;
   logic [7:0]             w_byte;
   logic                   w_tx_en;
   logic                   w_ack;
   logic                   w_last_byte;

   assign w_last_byte = (r_bidx == BIW'(BPW - 1));

   uart_tx_byte_sender u_sender (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_req),
      .i_byte    (w_byte),
      .i_tx_busy (tx_busy),
      .i_tx_done (tx_done),
      .o_tx_byte (tx_byte),
      .o_tx_en   (w_tx_en),
      .o_ack     (w_ack)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      w_next = r_state;
      w_req  = 1'b0;
      w_byte = 8'h00;
      case (r_state)
         S_IDLE:  if (start) w_next = S_HDR;
         S_HDR: begin
            w_req  = 1'b1;
            w_byte = START_BYTE;
            if (w_tx_en) w_next = S_HDR_W;
         end
         S_HDR_W: begin
            w_byte = START_BYTE;
            if (w_ack) w_next = (r_count == '0) ? S_END : S_RD;
         end
         S_RD:    w_next = S_LAT;
         S_LAT:   w_next = S_CAP;
         S_CAP:   w_next = S_DAT;
         S_DAT: begin
            w_req  = 1'b1;
            w_byte = r_shreg[INSTR_WIDTH-1 -: 8];
            if (w_tx_en) w_next = S_DAT_W;
         end
         S_DAT_W: begin
            w_byte = r_shreg[INSTR_WIDTH-1 -: 8];
            if (w_ack) begin
               if (!w_last_byte)         w_next = S_DAT;
               else if (r_count == CW'(1)) w_next = S_END;
               else                      w_next = S_RD;
            end
         end
         S_END: begin
            w_req  = 1'b1;
            w_byte = END_BYTE;
            if (w_tx_en) w_next = S_END_W;
         end
         S_END_W: begin
            w_byte = END_BYTE;
            if (w_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr        <= '0;
         r_count       <= '0;
         r_shreg       <= '0;
         r_bidx        <= '0;
         r_mem_rd_addr <= '0;
         r_done        <= 1'b0;
      end else begin
         r_done <= (r_state == S_END_W) && w_ack;
         case (r_state)
            S_IDLE: if (start) begin
               r_addr  <= start_addr;
               r_count <= (word_count > CW'(DEPTH)) ? CW'(DEPTH) : word_count;
            end
            S_RD:  r_mem_rd_addr <= r_addr;
            S_CAP: begin
               r_shreg <= mem_rd_data;
               r_bidx  <= '0;
            end
            S_DAT_W: if (w_ack) begin
               r_shreg <= r_shreg << 8;
               r_bidx  <= r_bidx + 1'b1;
               // Address wraps naturally at DEPTH.
               if (w_last_byte) begin
                  r_count <= r_count - 1'b1;
                  r_addr  <= r_addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign tx_en       = w_tx_en;
   assign mem_rd_addr = r_mem_rd_addr;

endmodule
